// File: rtl/axis_snapshot_capture_pkg.sv
// Shared definitions for the snapshot capture path.
// Holds the capture state encoding and the depth helpers.
package axis_snapshot_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_e;

  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DEPTH = 1 << ADDR_WIDTH_DEF;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/axis_snapshot_capture_ram.sv
// snapshot_ram: simple dual-port synchronous RAM, read-first.
// Ports: clk, rst (clears read register only), we/wr_addr/wr_data, rd_addr/rd_data.
module snapshot_ram
  import axis_snapshot_capture_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH_P = DEPTH,
  parameter int AW = $clog2(DEPTH_P)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH_P];
  logic [WIDTH-1:0] rd_data_q;

  // Array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Separate process samples the pre-write word (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axis_snapshot_capture.sv
// Captures a decimated block of tap-stream samples into RAM on start.
// Ports: aclk/areset, S_AXIS tap, start/abort/decimation, busy/done/sample_count, rd_addr/rd_data.
module axis_snapshot_capture
  import axis_snapshot_capture_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEC_WIDTH = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        S_AXIS_tready,
  input  logic                        start,
  input  logic                        abort,
  input  logic [DEC_WIDTH-1:0]        decimation,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_WIDTH:0]         sample_count,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [AXIS_TDATA_WIDTH-1:0] rd_data
);

  cap_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [DEC_WIDTH-1:0]  dec_cnt_q, dec_cnt_d;
  logic [DEC_WIDTH-1:0]  dec_reload_q, dec_reload_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  we;

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    cnt_d        = cnt_q;
    dec_cnt_d    = dec_cnt_q;
    dec_reload_d = dec_reload_q;
    busy_d       = busy_q;
    done_d       = done_q;
    we           = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_CAPTURE;
          dec_reload_d = decimation;
          dec_cnt_d    = '0;
          wr_addr_d    = '0;
          cnt_d        = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else if (S_AXIS_tvalid) begin
          if (dec_cnt_q == '0) begin
            we        = 1'b1;
            wr_addr_d = wr_addr_q + 1'b1;
            cnt_d     = cnt_q + 1'b1;
            dec_cnt_d = dec_reload_q;
            // Writing the last address completes the block.
            if (&wr_addr_q) begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            dec_cnt_d = dec_cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      wr_addr_q    <= '0;
      cnt_q        <= '0;
      dec_cnt_q    <= '0;
      dec_reload_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      cnt_q        <= cnt_d;
      dec_cnt_q    <= dec_cnt_d;
      dec_reload_q <= dec_reload_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  snapshot_ram #(
    .WIDTH   (AXIS_TDATA_WIDTH),
    .DEPTH_P (depth_of(ADDR_WIDTH)),
    .AW      (ADDR_WIDTH)
  ) u_ram (
    .clk     (aclk),
    .rst     (areset),
    .we      (we),
    .wr_addr (wr_addr_q),
    .wr_data (S_AXIS_tdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign S_AXIS_tready = 1'b1;
  assign busy          = busy_q;
  assign done          = done_q;
  assign sample_count  = cnt_q;

endmodule

// File: tb/tb_axis_snapshot_capture.sv
// Directed bench for axis_snapshot_capture, 16-deep capture.
// One task per scenario, inline checks, one summary line.
module tb_axis_snapshot_capture;

  localparam int W  = 32;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          tvalid;
  logic [W-1:0]  tdata;
  logic          tready;
  logic          start;
  logic          abort;
  logic [DW-1:0] decimation;
  logic          busy;
  logic          done;
  logic [AW:0]   sample_count;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;

  int tests = 0;
  int fails = 0;

  axis_snapshot_capture #(
    .AXIS_TDATA_WIDTH (W),
    .ADDR_WIDTH       (AW),
    .DEC_WIDTH        (DW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .S_AXIS_tvalid (tvalid),
    .S_AXIS_tdata  (tdata),
    .S_AXIS_tready (tready),
    .start         (start),
    .abort         (abort),
    .decimation    (decimation),
    .busy          (busy),
    .done          (done),
    .sample_count  (sample_count),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_start(input logic [DW-1:0] dec);
    decimation = dec;
    start = 1'b1;
    tick();
    start = 1'b0;
    decimation = 16'hFFFF;
  endtask

  task automatic feed_block(input logic [W-1:0] base);
    for (int i = 0; i < 16; i++) begin
      tvalid = 1'b1;
      tdata  = base + W'(i);
      tick();
    end
    tvalid = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1; tvalid = 1'b0; tdata = '0; start = 1'b0;
    abort = 1'b0; decimation = '0; rd_addr = '0;
    tick(); tick();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL reset_flags got busy=%b done=%b exp 0/0", busy, done);
    end
    tests++;
    if (sample_count !== 5'd0 || rd_data !== 32'd0) begin
      fails++; $display("FAIL reset_data got cnt=%0d rd=%0h exp 0/0", sample_count, rd_data);
    end
    tests++;
    if (tready !== 1'b1) begin
      fails++; $display("FAIL tready got %b exp 1", tready);
    end
    #2 areset = 1'b0;
    tick();
  endtask

  task automatic test_full_capture();
    pulse_start(16'd0);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || sample_count !== 5'd0) begin
      fails++; $display("FAIL full_start got busy=%b done=%b cnt=%0d exp 1/0/0", busy, done, sample_count);
    end
    for (int i = 0; i < 16; i++) begin
      tvalid = 1'b1;
      tdata  = W'(i);
      tick();
      if (i == 14) begin
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || sample_count !== 5'd15) begin
          fails++; $display("FAIL full_beat14 got busy=%b done=%b cnt=%0d exp 1/0/15", busy, done, sample_count);
        end
      end
    end
    tvalid = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b1 || sample_count !== 5'd16) begin
      fails++; $display("FAIL full_done got busy=%b done=%b cnt=%0d exp 0/1/16", busy, done, sample_count);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = AW'(a);
      tick();
      tests++;
      if (rd_data !== W'(a)) begin
        fails++; $display("FAIL full_read[%0d] got %0h exp %0h", a, rd_data, a);
      end
    end
    tick();
    tests++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL full_sticky got done=%b exp 1", done);
    end
  endtask

  task automatic test_decimation();
    pulse_start(16'd2);
    for (int b = 0; b < 48; b++) begin
      tvalid = 1'b1;
      tdata  = W'(b);
      tick();
      tvalid = 1'b0;
      tdata  = 32'hDEAD_BEEF;
      tick();
      if (b == 44) begin
        tests++;
        if (busy !== 1'b1 || sample_count !== 5'd15) begin
          fails++; $display("FAIL dec_beat44 got busy=%b cnt=%0d exp 1/15", busy, sample_count);
        end
      end
      if (b == 45) begin
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || sample_count !== 5'd16) begin
          fails++; $display("FAIL dec_done got done=%b busy=%b cnt=%0d exp 1/0/16", done, busy, sample_count);
        end
      end
    end
    for (int k = 0; k < 16; k++) begin
      rd_addr = AW'(k);
      tick();
      tests++;
      if (rd_data !== W'(3 * k)) begin
        fails++; $display("FAIL dec_read[%0d] got %0h exp %0h", k, rd_data, 3 * k);
      end
    end
  endtask

  task automatic test_abort();
    pulse_start(16'd0);
    for (int i = 0; i < 5; i++) begin
      tvalid = 1'b1;
      tdata  = 32'd100 + W'(i);
      tick();
    end
    tdata = 32'd999;
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    tvalid = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sample_count !== 5'd5) begin
      fails++; $display("FAIL abort_state got busy=%b done=%b cnt=%0d exp 0/0/5", busy, done, sample_count);
    end
    tick();
    tests++;
    if (busy !== 1'b0 || sample_count !== 5'd5) begin
      fails++; $display("FAIL abort_hold got busy=%b cnt=%0d exp 0/5", busy, sample_count);
    end
    rd_addr = 4'd5;
    tick();
    tests++;
    if (rd_data !== 32'd15) begin
      fails++; $display("FAIL abort_nowrite got %0h exp f", rd_data);
    end
    rd_addr = 4'd4;
    tick();
    tests++;
    if (rd_data !== 32'd104) begin
      fails++; $display("FAIL abort_last got %0h exp 68", rd_data);
    end
    pulse_start(16'd0);
    tests++;
    if (busy !== 1'b1 || sample_count !== 5'd0) begin
      fails++; $display("FAIL abort_restart got busy=%b cnt=%0d exp 1/0", busy, sample_count);
    end
    feed_block(32'd200);
    tests++;
    if (done !== 1'b1 || sample_count !== 5'd16) begin
      fails++; $display("FAIL abort_refill got done=%b cnt=%0d exp 1/16", done, sample_count);
    end
  endtask

  task automatic test_start_during_capture();
    pulse_start(16'd0);
    for (int i = 0; i < 16; i++) begin
      tvalid = 1'b1;
      tdata  = 32'd300 + W'(i);
      start  = (i == 3 || i == 9);
      tick();
    end
    tvalid = 1'b0;
    start  = 1'b0;
    tests++;
    if (done !== 1'b1 || sample_count !== 5'd16) begin
      fails++; $display("FAIL restart_done got done=%b cnt=%0d exp 1/16", done, sample_count);
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = AW'(a);
      tick();
      tests++;
      if (rd_data !== 32'd300 + W'(a)) begin
        fails++; $display("FAIL restart_read[%0d] got %0h exp %0h", a, rd_data, 300 + a);
      end
    end
  endtask

  task automatic test_reset_mid();
    pulse_start(16'd0);
    for (int i = 0; i < 7; i++) begin
      tvalid = 1'b1;
      tdata  = 32'd400 + W'(i);
      tick();
    end
    tdata = 32'd407;
    #2 areset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sample_count !== 5'd0 || rd_data !== 32'd0) begin
      fails++; $display("FAIL rstmid got busy=%b done=%b cnt=%0d rd=%0h exp 0", busy, done, sample_count, rd_data);
    end
    tvalid = 1'b0;
    tick();
    #2 areset = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || sample_count !== 5'd0) begin
      fails++; $display("FAIL rstmid_release got busy=%b cnt=%0d exp 0/0", busy, sample_count);
    end
    pulse_start(16'd0);
    feed_block(32'd500);
    tests++;
    if (done !== 1'b1 || sample_count !== 5'd16) begin
      fails++; $display("FAIL rstmid_fresh got done=%b cnt=%0d exp 1/16", done, sample_count);
    end
    rd_addr = 4'd0;
    tick();
    tests++;
    if (rd_data !== 32'd500) begin
      fails++; $display("FAIL rstmid_addr0 got %0h exp 1f4", rd_data);
    end
  endtask

  task automatic test_read_first();
    pulse_start(16'd0);
    feed_block(32'd0);
    pulse_start(16'd0);
    rd_addr = 4'd2;
    tvalid = 1'b1;
    tdata  = 32'h10;
    tick();
    tdata  = 32'h11;
    tick();
    tdata  = 32'hA5A5_A5A5;
    tick();
    tvalid = 1'b0;
    tests++;
    if (rd_data !== 32'h2) begin
      fails++; $display("FAIL rdfirst_old got %0h exp 2", rd_data);
    end
    tick();
    tests++;
    if (rd_data !== 32'hA5A5_A5A5) begin
      fails++; $display("FAIL rdfirst_new got %0h exp a5a5a5a5", rd_data);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || sample_count !== 5'd3) begin
      fails++; $display("FAIL rdfirst_abort got busy=%b cnt=%0d exp 0/3", busy, sample_count);
    end
  endtask

  initial begin
    test_reset();
    test_full_capture();
    test_decimation();
    test_abort();
    test_start_during_capture();
    test_reset_mid();
    test_read_first();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_snapshot_capture.md
Name: axis_snapshot_capture

Overview:
- Consumes the free-running tap stream produced by the stream sniffer (the copy that ignores backpressure).
- On a software start pulse, records a decimated block of consecutive samples into on-chip RAM, then flags completion.
- The processor-side register bridge reads the captured block back through a synchronous read port.
- Sits directly downstream of the sniffer's tap output, in parallel with the main signal path.

Parameters:
- AXIS_TDATA_WIDTH, 32, sample width in bits.
- ADDR_WIDTH, 10, capture depth = 2^ADDR_WIDTH samples.
- DEC_WIDTH, 16, width of the decimation factor.

Ports:
- aclk  input  1  system clock; all logic on rising edge.
- areset  input  1  asynchronous, active-high reset.
- S_AXIS_tvalid  input  1  tap stream sample valid.
- S_AXIS_tdata  input  AXIS_TDATA_WIDTH  tap stream sample.
- S_AXIS_tready  output  1  constant 1; the block never stalls the tap.
- start  input  1  single-cycle capture request.
- abort  input  1  single-cycle request to stop a capture in progress.
- decimation  input  DEC_WIDTH  keep 1 of (decimation+1) valid beats; latched at start.
- busy  output  1  high while capturing.
- done  output  1  high once a full block is captured; sticky until next start.
- sample_count  output  ADDR_WIDTH+1  number of samples written in the current or last capture.
- rd_addr  input  ADDR_WIDTH  readout address.
- rd_data  output  AXIS_TDATA_WIDTH  registered RAM word at rd_addr.

Behaviour:
- Reset (async assert, sync release): state IDLE, busy=0, done=0, sample_count=0, rd_data=0, internal write address and decimation counter = 0. RAM contents are not reset.
- States: IDLE, CAPTURE, DONE.
- IDLE/DONE + start: go to CAPTURE on the next edge.
  - Latch decimation into dec_reload; load dec_cnt=0 so the first valid beat is kept.
  - Clear wr_addr and sample_count. Set busy=1, done=0.
- CAPTURE, per cycle with S_AXIS_tvalid=1:
  - dec_cnt==0: write tdata to RAM[wr_addr], wr_addr+1, sample_count+1, dec_cnt<=dec_reload.
  - dec_cnt!=0: dec_cnt-1, no write.
  - tvalid=0: nothing changes.
- CAPTURE end: the write to address 2^ADDR_WIDTH-1 moves to DONE on the same edge (busy=0, done=1, sample_count=2^ADDR_WIDTH). wr_addr wraps to 0, unused.
- Decimation=0 keeps every valid beat. Decimation=N keeps beats 0, N+1, 2(N+1), … counted in valid beats, not cycles.
- start while in CAPTURE: ignored; the capture continues unchanged.
- abort in CAPTURE: to IDLE on the next edge with busy=0, done=0; sample_count holds the partial count. abort in IDLE/DONE is ignored.
- start and abort in the same cycle:
  - In CAPTURE, abort wins.
  - In IDLE/DONE, start wins.
- A sample arriving in the abort cycle is not written.
- Readout latency: rd_data updates 1 cycle after rd_addr; always enabled, in every state.
- Read and write to the same address in the same cycle: rd_data returns the old content (read-first).
- Reset mid-capture: immediately IDLE, outputs at reset values; partially written RAM is left as-is.
- The decimation input is ignored except in the start cycle.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2) and a DEPTH = 2^ADDR_WIDTH helper constant. Other stream stages reuse both.
- One sub-module: snapshot_ram, a simple dual-port (1 write, 1 read) synchronous RAM.
  - Parameterised by width and depth, read-first, inferable as block RAM.
  - The controller (FSM, decimation counter, write address) stays in the top module.

Test Plan:
- ADDR_WIDTH=4, decimation=0, start, then tvalid=1 with tdata=0..15 on consecutive cycles -> busy for 16 beats; done=1 the cycle after beat 15; sample_count=16; reading addr 0..15 returns 0..15 with 1-cycle latency.
- decimation=2, tdata = beat index 0..47 with tvalid toggling 1/0 -> RAM holds 0,3,6,…,45; done after the 16th kept beat; invalid cycles never counted.
- Abort after 5 kept samples, with start asserted in the same cycle -> IDLE, done=0, sample_count=5; a later start restarts with sample_count=0 and a full capture succeeds.
- start pulses during CAPTURE at beats 3 and 9 -> no restart; RAM content identical to an uninterrupted run.
- areset asserted mid-capture (beat 7) -> busy, done, sample_count and rd_data go to 0 asynchronously; after release, a start begins a fresh capture from addr 0.
- Reading addr 2 in the same cycle that addr 2 is written with 0xA5A5A5A5 (old value 0x2) -> rd_data=0x2 next cycle, 0xA5A5A5A5 on a re-read.
